alu16_seq: RTL and testbench
============================

ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: operation request valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-005 SHALL have ports a and b, input, 16 bits each: operands.
REQ-006 SHALL have port s, input, 4 bits: function select.
REQ-007 SHALL have port m, input, 1 bit: 1 = logic mode, 0 = arithmetic mode.
REQ-008 SHALL have port cin, input, 1 bit: carry-in to bit 0.
REQ-009 SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port f, output, 16 bits: result.
REQ-012 SHALL have port cout, output, 1 bit: carry out of bit 15.
REQ-013 SHALL have port zero, output, 1 bit: f == 16'h0000.

Function
REQ-014 SHALL process the 16-bit operation as four 4-bit slices, LSB slice first, one slice per clock, through one instance of the team's sum module.
REQ-015 SHALL form per bit i of the current slice: P = a|(b&s[0])|(~b&s[1]) and G = (a&b&s[3])|(a&~b&s[2]), and drive E=P, D=G, M=m into sum.
REQ-016 SHALL drive sum's C with the in-slice ripple carries: C[0] = carry register; C[k+1] = G[k] | (P[k]&C[k]).
REQ-017 SHALL update the carry register to G[3] | (P[3]&C[3]) after each slice when m=0, and hold it at 0 when m=1.
REQ-018 SHALL implement FSM states IDLE, RUN and DONE.
REQ-019 SHALL, in IDLE, drive in_ready=1; when in_valid=1, latch a, b, s, m, load carry=cin (0 if m=1), clear the slice counter, and go to RUN.
REQ-020 SHALL, in RUN, write slice n into f[4n+3:4n], increment the counter, and go to DONE after slice 3.
REQ-021 SHALL drive out_valid=1 only in DONE; with a request accepted at edge T, out_valid rises after edge T+4.
REQ-022 SHALL, in DONE, hold f, cout and zero stable until out_ready=1, then go to IDLE on that edge.
REQ-023 SHALL drive in_ready=0 in RUN and DONE and ignore in_valid there; no new request is accepted on the edge that leaves DONE.
REQ-024 SHALL drive cout from the final carry register value (0 in logic mode), and zero from the full assembled f.
REQ-025 SHALL ignore input changes after latching; results depend only on the latched operands.

Reset
REQ-026 SHALL, on rst_n=0, immediately force state=IDLE, counter=0, carry=0, f=0, cout=0, in_ready=1, out_valid=0, and zero=1 (consistent with f=0).
REQ-027 SHALL, on reset in RUN or DONE, discard the operation with no partial out_valid.

Configuration
REQ-028 SHALL, with macro ALU16_SEQ_OVF_FLAG_EN defined, add output port ovf (1 bit) = carry into bit 15 XOR cout when m=0, 0 when m=1, registered with f, and reset to 0.
REQ-029 SHALL, without ALU16_SEQ_OVF_FLAG_EN, omit the ovf port and logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover add: s=4'b1001, m=0, cin=0, a=16'h1234, b=16'h0FFF -> f=16'h2233, cout=0, zero=0, out_valid 4 edges after accept.
REQ-031 SHALL cover wrap: s=4'b1001, m=0, cin=0, a=16'hFFFF, b=16'h0001 -> f=16'h0000, cout=1, zero=1; with the macro, a=16'h7FFF, b=16'h0001 -> f=16'h8000, ovf=1.
REQ-032 SHALL cover subtract: s=4'b0110, m=0, cin=1, a=16'h0005, b=16'h0007 -> f=16'hFFFE, cout=0.
REQ-033 SHALL cover logic XOR: s=4'b0110, m=1, a=16'hF0F0, b=16'hFF00 -> f=16'h0FF0, cout=0.
REQ-034 SHALL cover backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1 -> f stable, in_ready=0, no second accept; accept follows out_ready=1 plus one IDLE cycle.
REQ-035 SHALL cover reset mid-operation: rst_n low during RUN slice 2 -> f=0, out_valid=0, in_ready=1 immediately, and a following add computes correctly.

Source files
------------

// File: rtl/alu16_seq.sv
`timescale 1ns/1ps
// alu16_seq: 16-bit 74181-style ALU run as four 4-bit slices, LSB first, one per clock.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready + a, b, s, m, cin request;
//   out_valid/out_ready + f, cout, zero result. Define ALU16_SEQ_OVF_FLAG_EN to add ovf.

module sum (
  input  logic [3:0] E,
  input  logic [3:0] D,
  input  logic       M,
  input  logic [3:0] C,
  output logic [3:0] F
);
  // D is always a subset of E, so E^D is the half-sum.
  // Logic mode yields the complemented half-sum.
  assign F = M ? ~(E ^ D) : (E ^ D ^ C);
endmodule

module alu16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  s,
  input  logic        m,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] f,
  output logic        cout,
  output logic        zero
`ifdef ALU16_SEQ_OVF_FLAG_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  s_q, s_d;
  logic        m_q, m_d;
  logic [15:0] f_q, f_d;
  logic        cout_q, cout_d;
`ifdef ALU16_SEQ_OVF_FLAG_EN
  logic        ovf_q, ovf_d;
`endif

  logic [3:0] a_sl, b_sl, p, g, sl_f;
  logic [4:0] c;

  always_comb begin
    a_sl = a_q[{cnt_q, 2'b00} +: 4];
    b_sl = b_q[{cnt_q, 2'b00} +: 4];
    p = a_sl | (b_sl & {4{s_q[0]}})
      | (~b_sl & {4{s_q[1]}});
    g = (a_sl & b_sl & {4{s_q[3]}})
      | (a_sl & ~b_sl & {4{s_q[2]}});
    c    = 5'b0;
    c[0] = carry_q;
    for (int k = 0; k < 4; k++) begin
      c[k+1] = g[k] | (p[k] & c[k]);
    end
  end

  sum u_sum (
    .E (p),
    .D (g),
    .M (m_q),
    .C (c[3:0]),
    .F (sl_f)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    f_d     = f_q;
    cout_d  = cout_q;
`ifdef ALU16_SEQ_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          carry_d = cin & ~m;
          cnt_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        f_d[{cnt_q, 2'b00} +: 4] = sl_f;
        carry_d = c[4] & ~m_q;
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cout_d  = c[4] & ~m_q;
`ifdef ALU16_SEQ_OVF_FLAG_EN
          ovf_d   = (c[3] ^ c[4]) & ~m_q;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      carry_q <= 1'b0;
      a_q     <= 16'h0;
      b_q     <= 16'h0;
      s_q     <= 4'h0;
      m_q     <= 1'b0;
      f_q     <= 16'h0;
      cout_q  <= 1'b0;
`ifdef ALU16_SEQ_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
`ifdef ALU16_SEQ_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign f         = f_q;
  assign cout      = cout_q;
  assign zero      = (f_q == 16'h0);
`ifdef ALU16_SEQ_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu16_seq.sv
`timescale 1ns/1ps
// tb_alu16_seq: scoreboard bench for alu16_seq.
// Random and directed requests; expected results queued at accept, checked on output.

module tb_alu16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = 16'h0, b = 16'h0;
  logic [3:0]  s = 4'h0;
  logic        m = 1'b0, cin = 1'b0;
  logic        in_ready, out_valid, cout, zero;
  logic [15:0] f;
  logic        ovf_w;

  alu16_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .m         (m),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .cout      (cout),
    .zero      (zero)
`ifdef ALU16_SEQ_OVF_FLAG_EN
    ,
    .ovf       (ovf_w)
`endif
  );

`ifndef ALU16_SEQ_OVF_FLAG_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] f;
    logic        cout;
    logic        zero;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pops = 0;
  bit   bp_mode = 1'b0;
  bit   seen = 1'b0;
  logic [15:0] last_f;
  logic        last_cout, last_zero, last_ovf;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: arithmetic is P + G + cin as plain 17-bit addition;
  // logic mode is the complement of P xor G.
  function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib,
                                 input logic [3:0] is, input logic im,
                                 input logic ic);
    exp_t e;
    logic [15:0] p, g, lo;
    logic [16:0] t;
    p = ia | (ib & {16{is[0]}}) | (~ib & {16{is[1]}});
    g = (ia & ib & {16{is[3]}}) | (ia & ~ib & {16{is[2]}});
    if (im) begin
      e.f = ~(p ^ g);
      e.cout = 1'b0;
      e.ovf = 1'b0;
    end else begin
      t  = {1'b0, p} + {1'b0, g} + {16'h0, ic};
      lo = {1'b0, p[14:0]} + {1'b0, g[14:0]} + {15'h0, ic};
      e.f = t[15:0];
      e.cout = t[16];
      e.ovf = lo[15] ^ t[16];
    end
    e.zero = (e.f == 16'h0);
    e.acc = 0;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (!bp_mode) begin
      #1 out_ready = ($urandom % 4) != 0;
    end
  end

  // Accept observer: request seen now is taken on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && in_valid && in_ready) begin
      e = model(a, b, s, m, cin);
      e.acc = cyc + 1;
      q.push_back(e);
    end
  end

  // Monitor: compares on every handshake, independent of the driver.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got f=%h with empty queue", f);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", cyc - q[0].acc, 4);
        end
        chk("in_ready_done", in_ready, 0);
        if (out_ready) begin
          chk("f", f, q[0].f);
          chk("cout", cout, q[0].cout);
          chk("zero", zero, q[0].zero);
`ifdef ALU16_SEQ_OVF_FLAG_EN
          chk("ovf", ovf_w, q[0].ovf);
`endif
          last_f = f;
          last_cout = cout;
          last_zero = zero;
          last_ovf = ovf_w;
          void'(q.pop_front());
          seen = 1'b0;
          pops++;
        end
      end
    end
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                       input logic [3:0] is, input logic im, input logic ic,
                       input bit keep);
    bit acc;
    int n;
    @(posedge clk);
    #1;
    a = ia; b = ib; s = is; m = im; cin = ic;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = in_ready && rst_n;
      @(posedge clk);
      n++;
    end
    #1;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
    if (!keep) begin
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      s = 4'($urandom);
      m = 1'($urandom);
      cin = 1'($urandom);
    end
  endtask

  task automatic wait_pops(input int target);
    int n;
    n = 0;
    while (pops < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (pops < target) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got %0d results expected %0d", pops, target);
    end
  endtask

  task automatic directed(input string nm, input logic [15:0] ia,
                          input logic [15:0] ib, input logic [3:0] is,
                          input logic im, input logic ic,
                          input logic [15:0] ef, input logic ec,
                          input logic ez);
    int p0;
    p0 = pops;
    issue(ia, ib, is, im, ic, 1'b0);
    wait_pops(p0 + 1);
    chk({nm, "_f"}, last_f, ef);
    chk({nm, "_cout"}, last_cout, ec);
    chk({nm, "_zero"}, last_zero, ez);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] ra, rb;
    #1;
    chk("rst_f", f, 16'h0);
    chk("rst_zero", zero, 1);
    chk("rst_cout", cout, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
`ifdef ALU16_SEQ_OVF_FLAG_EN
    chk("rst_ovf", ovf_w, 0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    directed("add", 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0,
             16'h2233, 1'b0, 1'b0);
    directed("wrap", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0,
             16'h0000, 1'b1, 1'b1);
`ifdef ALU16_SEQ_OVF_FLAG_EN
    directed("ovf", 16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0,
             16'h8000, 1'b0, 1'b0);
    chk("ovf_flag", last_ovf, 1);
`endif
    directed("sub", 16'h0005, 16'h0007, 4'b0110, 1'b0, 1'b1,
             16'hFFFE, 1'b0, 1'b0);
    directed("xor", 16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1,
             16'h0FF0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 8 == 1) ra = 16'hFFFF;
      if (i % 8 == 2) rb = 16'h0000;
      issue(ra, rb, 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
    wait_pops(pops + q.size());

    // Backpressure with a second request pending.
    bp_mode = 1'b1;
    @(posedge clk);
    #2 out_ready = 1'b0;
    issue(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 1'b0);
    a = 16'hFFFF; b = 16'h0001; s = 4'b1001; m = 1'b0; cin = 1'b0;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_f_stable", f, 16'h2233);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_no_accept", q.size(), 1);
      @(posedge clk);
      if (i < 2) @(negedge clk);
    end
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_no_accept_leave", q.size(), 0);
    @(posedge clk);
    #1;
    chk("bp_second_accept", in_ready, 0);
    chk("bp_queue", q.size(), 1);
    in_valid = 1'b0;
    bp_mode = 1'b0;
    wait_pops(pops + 1);
    chk("bp2_f", last_f, 16'h0000);
    chk("bp2_cout", last_cout, 1);
    chk("bp2_zero", last_zero, 1);

    // Reset while slice 2 is in flight.
    issue(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_partial_f", f, 16'h0033);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_f", f, 16'h0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_zero", zero, 1);
    q.delete();
    seen = 1'b0;
    #4;
    @(negedge clk);
    chk("mid_rst_hold_valid", out_valid, 0);
    rst_n = 1'b1;
    directed("post_rst", 16'hABCD, 16'h1234, 4'b1001, 1'b0, 1'b0,
             16'hBE01, 1'b0, 1'b0);

    wait_pops(pops + q.size());
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
